// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: control FSM that sequences weight-row load, input-row streaming and psum drain per input channel
// Ports: CLK/RESETN clock and sync active-low reset; start/abort with param_R/S/C/rows request or cancel a pass;
// w_valid/w_ready and i_valid/i_ready are the weight/input row handshakes; mac_done marks a psum row leaving the array;
// weight_row_wr_en/idx, stall, psum_feedback_sel, out_wr_en steer the PE array; busy/done/err report status.
module conv_pass_sequencer #(
  parameter int PE_ROWS        = 5,
  parameter int PE_COLS        = 5,
  parameter int MAC_PIPE_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  param_R,
  input  logic [3:0]  param_S,
  input  logic [11:0] param_C,
  input  logic [7:0]  param_rows,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        mac_done,
  output logic        weight_row_wr_en,
  output logic [2:0]  weight_row_wr_idx,
  output logic        stall,
  output logic        psum_feedback_sel,
  output logic        out_wr_en,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  localparam logic [3:0] MAX_R = 4'(PE_ROWS);
  localparam logic [3:0] MAX_S = 4'(PE_COLS);
  state_t      state_q, state_d;
  logic [3:0]  r_q, r_d, s_q, s_d;
  logic [11:0] c_q, c_d, ch_q, ch_d;
  logic [7:0]  rows_q, rows_d, icnt_q, icnt_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [8:0]  pending_q, pending_d;
  logic        err_q, err_d;
  logic        params_ok, start_ok, w_acc, i_acc, last_w, last_i, last_ch, in_sd, drained;
  assign params_ok = param_R != 4'd0 && param_R <= MAX_R && param_S != 4'd0 && param_S <= MAX_S &&
                     param_C != 12'd0 && param_rows != 8'd0;
  assign start_ok  = state_q == IDLE && start && !abort && params_ok;
  assign w_acc     = state_q == LOAD_W && w_valid;
  assign i_acc     = state_q == STREAM && i_valid;
  assign last_w    = {1'b0, wcnt_q} == r_q - 4'd1;
  assign last_i    = icnt_q == rows_q - 8'd1;
  assign last_ch   = ch_q == c_q - 12'd1;
  assign in_sd     = state_q == STREAM || state_q == DRAIN;
  assign drained   = state_q == DRAIN && pending_q == 9'd0;
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      r_q       <= 4'd0;
      s_q       <= 4'd0;
      c_q       <= 12'd0;
      rows_q    <= 8'd0;
      ch_q      <= 12'd0;
      wcnt_q    <= 3'd0;
      icnt_q    <= 8'd0;
      pending_q <= 9'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      s_q       <= s_d;
      c_q       <= c_d;
      rows_q    <= rows_d;
      ch_q      <= ch_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && params_ok ? LOAD_W : IDLE;
      LOAD_W:  state_d = w_acc && last_w ? STREAM : LOAD_W;
      STREAM:  state_d = i_acc && last_i ? DRAIN : STREAM;
      DRAIN:   state_d = pending_q != 9'd0 ? DRAIN : last_ch ? DONE : LOAD_W;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // Counter updates; abort clears everything so a later pass starts clean.
  always_comb begin
    r_d       = start_ok ? param_R : r_q;
    s_d       = start_ok ? param_S : s_q;
    c_d       = start_ok ? param_C : c_q;
    rows_d    = start_ok ? param_rows : rows_q;
    ch_d      = abort || start_ok ? 12'd0 : drained && !last_ch ? ch_q + 12'd1 : ch_q;
    wcnt_d    = abort || start_ok || (w_acc && last_w) ? 3'd0 : w_acc ? wcnt_q + 3'd1 : wcnt_q;
    icnt_d    = abort || start_ok || (w_acc && last_w) ? 8'd0 : i_acc ? icnt_q + 8'd1 : icnt_q;
    pending_d = abort ? 9'd0 :
                i_acc && !mac_done ? pending_q + 9'd1 :
                mac_done && !i_acc && pending_q != 9'd0 ? pending_q - 9'd1 : pending_q;
    // A psum row arriving with nothing outstanding means the array and sequencer disagree.
    err_d     = (state_q == IDLE && start && !abort && !params_ok) || (mac_done && pending_q == 9'd0);
  end
  // Outputs are forced to their idle values while reset is held, even before the reset edge lands.
  always_comb begin
    busy              = RESETN && state_q != IDLE;
    done              = RESETN && state_q == DONE && !abort;
    err               = RESETN && err_q;
    w_ready           = RESETN && state_q == LOAD_W;
    i_ready           = RESETN && state_q == STREAM;
    weight_row_wr_en  = w_ready && w_valid;
    weight_row_wr_idx = RESETN ? wcnt_q : 3'd0;
    stall             = !RESETN || !in_sd ? 1'b1 : state_q == STREAM && !i_valid;
    psum_feedback_sel = RESETN && in_sd && ch_q != 12'd0;
    out_wr_en         = RESETN && in_sd && last_ch && mac_done;
  end
  if (MAC_PIPE_DEPTH >= 1) begin : g_chk
    assert property (@(posedge CLK) disable iff (!RESETN) busy |-> (s_q != 4'd0 && s_q <= MAX_S));
  end
endmodule

// File: tb/tb_conv_pass_sequencer.sv
// tb_conv_pass_sequencer: directed, table-driven self-checking bench for conv_pass_sequencer
module tb_conv_pass_sequencer;
  logic        CLK = 1'b0, RESETN = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  pR = 4'd0, pS = 4'd0;
  logic [11:0] pC = 12'd0;
  logic [7:0]  prows = 8'd0;
  logic        w_valid = 1'b0, i_valid = 1'b0, mac_done = 1'b0;
  logic        w_ready, i_ready, weight_row_wr_en, stall, psum_feedback_sel, out_wr_en, busy, done, err;
  logic [2:0]  weight_row_wr_idx;
  int          n_tests = 0, n_fail = 0;
  int          nwr, bad, acc, o0, o1, o2, rounds, dcyc;

  conv_pass_sequencer #(.PE_ROWS(5), .PE_COLS(5), .MAC_PIPE_DEPTH(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .abort(abort),
    .param_R(pR), .param_S(pS), .param_C(pC), .param_rows(prows),
    .w_valid(w_valid), .w_ready(w_ready), .i_valid(i_valid), .i_ready(i_ready),
    .mac_done(mac_done), .weight_row_wr_en(weight_row_wr_en), .weight_row_wr_idx(weight_row_wr_idx),
    .stall(stall), .psum_feedback_sel(psum_feedback_sel), .out_wr_en(out_wr_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  r, s;
    logic [11:0] c;
    logic [7:0]  rows;
    logic        exp_err, exp_busy;
  } pv_t;
  pv_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {23'd0, busy, done, err, w_ready, i_ready, weight_row_wr_en, out_wr_en, psum_feedback_sel, stall,
             weight_row_wr_idx}, 32'h8);
  endtask

  task automatic set_params(input logic [3:0] r, input logic [3:0] s, input logic [11:0] c, input logic [7:0] rows);
    pR = r; pS = s; pC = c; prows = rows;
  endtask

  // Runs one full pass with both valids held high; mac_done follows each input accept by 2 cycles.
  task automatic run_pass(input logic [3:0] r, input logic [11:0] c, input logic [7:0] rows,
                          output int n_wr, output int n_bad, output int n_acc,
                          output int out0, output int out1, output int out2,
                          output int n_rounds, output int done_cyc);
    int round, wexp;
    logic prev_wr;
    logic [1:0] hist;
    n_wr = 0; n_bad = 0; n_acc = 0; out0 = 0; out1 = 0; out2 = 0;
    round = -1; wexp = 0; prev_wr = 1'b0; hist = 2'b00; done_cyc = -1;
    set_params(r, 4'd3, c, rows);
    start = 1'b1; w_valid = 1'b1; i_valid = 1'b1; mac_done = 1'b0;
    nxt();
    start = 1'b0;
    for (int t = 1; t < 400 && done_cyc < 0; t++) begin
      mac_done = hist[1];
      #1;
      if (w_ready && !prev_wr) begin round++; wexp = 0; end
      prev_wr = w_ready;
      if (weight_row_wr_en) begin
        n_wr++;
        if (weight_row_wr_idx != 3'(wexp)) n_bad++;
        wexp++;
      end
      if (busy && !w_ready && !done) begin
        if (psum_feedback_sel != (round > 0)) n_bad++;
        if (stall) n_bad++;
      end else begin
        if (psum_feedback_sel) n_bad++;
        if (!stall) n_bad++;
      end
      if (out_wr_en) begin
        if (round == 0) out0++;
        else if (round == 1) out1++;
        else out2++;
      end
      if (i_valid && i_ready) n_acc++;
      hist = {hist[0], i_valid && i_ready};
      if (done) done_cyc = t;
      nxt();
    end
    n_rounds = round + 1;
    w_valid = 1'b0; i_valid = 1'b0; mac_done = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0] = '{r: 4'd6,  s: 4'd3, c: 12'd1,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[1] = '{r: 4'd0,  s: 4'd3, c: 12'd1,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[2] = '{r: 4'd3,  s: 4'd6, c: 12'd1,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[3] = '{r: 4'd3,  s: 4'd0, c: 12'd1,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[4] = '{r: 4'd3,  s: 4'd3, c: 12'd0,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[5] = '{r: 4'd3,  s: 4'd3, c: 12'd1,    rows: 8'd0,   exp_err: 1'b1, exp_busy: 1'b0};
    tbl[6] = '{r: 4'd5,  s: 4'd5, c: 12'd1,    rows: 8'd1,   exp_err: 1'b0, exp_busy: 1'b1};
    tbl[7] = '{r: 4'd1,  s: 4'd1, c: 12'd4095, rows: 8'd255, exp_err: 1'b0, exp_busy: 1'b1};
    tbl[8] = '{r: 4'd15, s: 4'd1, c: 12'd1,    rows: 8'd1,   exp_err: 1'b1, exp_busy: 1'b0};

    repeat (3) nxt();
    chk_rst("reset_state");
    RESETN = 1'b1;
    #1;
    chk_rst("after_reset_release");

    for (int i = 0; i < 9; i++) begin
      set_params(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].rows);
      start = 1'b1;
      nxt();
      start = 1'b0;
      #1;
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      nxt();
      chk($sformatf("vec%0d_err_pulse", i), 32'(err), 32'd0);
      abort = 1'b1;
      nxt();
      abort = 1'b0;
      #1;
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    set_params(4'd2, 4'd2, 12'd1, 8'd1);
    start = 1'b1; abort = 1'b1;
    nxt();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_over_start_busy", 32'(busy), 32'd0);
    chk("abort_over_start_err", 32'(err), 32'd0);

    run_pass(4'd3, 12'd1, 8'd4, nwr, bad, acc, o0, o1, o2, rounds, dcyc);
    chk("p1_wr_count", 32'(nwr), 32'd3);
    chk("p1_ctl_bad", 32'(bad), 32'd0);
    chk("p1_accepts", 32'(acc), 32'd4);
    chk("p1_out_pulses", 32'(o0), 32'd4);
    chk("p1_rounds", 32'(rounds), 32'd1);
    chk("p1_done_cycle", 32'(dcyc), 32'd11);
    chk("p1_done_width", 32'({done, busy}), 32'd0);

    run_pass(4'd2, 12'd3, 8'd2, nwr, bad, acc, o0, o1, o2, rounds, dcyc);
    chk("p3_wr_count", 32'(nwr), 32'd6);
    chk("p3_ctl_bad", 32'(bad), 32'd0);
    chk("p3_accepts", 32'(acc), 32'd6);
    chk("p3_out_round0", 32'(o0), 32'd0);
    chk("p3_out_round1", 32'(o1), 32'd0);
    chk("p3_out_round2", 32'(o2), 32'd2);
    chk("p3_rounds", 32'(rounds), 32'd3);
    chk("p3_done_cycle", 32'(dcyc), 32'd22);

    set_params(4'd1, 4'd1, 12'd1, 8'd3);
    start = 1'b1; w_valid = 1'b1;
    nxt();
    start = 1'b0;
    #1;
    chk("s45_wr", 32'({weight_row_wr_en, weight_row_wr_idx}), 32'h8);
    nxt();
    w_valid = 1'b0; i_valid = 1'b1;
    #1;
    chk("s45_stall_v1", 32'(stall), 32'd0);
    nxt();
    i_valid = 1'b0;
    #1;
    chk("s45_stall_v0", 32'(stall), 32'd1);
    nxt();
    i_valid = 1'b1; mac_done = 1'b1;
    #1;
    chk("s45_stall_v1b", 32'(stall), 32'd0);
    chk("s45_out_wr", 32'(out_wr_en), 32'd1);
    nxt();
    mac_done = 1'b0;
    nxt();
    i_valid = 1'b0; mac_done = 1'b1;
    #1;
    chk("s45_drain", 32'({busy, i_ready, stall}), 32'h4);
    nxt();
    nxt();
    mac_done = 1'b0;
    #1;
    chk("s45_no_err", 32'({err, done, busy}), 32'h1);
    nxt();
    chk("s45_done", 32'({done, busy}), 32'h3);
    nxt();
    chk("s45_after_done", 32'({done, busy}), 32'h0);

    set_params(4'd1, 4'd1, 12'd1, 8'd2);
    start = 1'b1; w_valid = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    w_valid = 1'b0; i_valid = 1'b1;
    nxt();
    nxt();
    i_valid = 1'b0;
    #1;
    chk("s46_in_drain", 32'({busy, i_ready, w_ready}), 32'h4);
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    #1;
    chk("s46_aborted", 32'({busy, done, stall}), 32'h1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk($sformatf("s46_no_done%0d", k), 32'({busy, done}), 32'h0);
    end
    mac_done = 1'b1;
    nxt();
    mac_done = 1'b0;
    #1;
    chk("s46_stray_err", 32'(err), 32'd1);
    nxt();
    chk("s46_err_pulse", 32'(err), 32'd0);

    set_params(4'd4, 4'd2, 12'd1, 8'd1);
    start = 1'b1; w_valid = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    chk("s47_idx1", 32'({weight_row_wr_en, weight_row_wr_idx}), 32'h9);
    nxt();
    RESETN = 1'b0; start = 1'b1; i_valid = 1'b1; mac_done = 1'b1;
    #1;
    chk_rst("s47_reset_held");
    nxt();
    chk_rst("s47_reset_edge");
    RESETN = 1'b1; start = 1'b0; w_valid = 1'b0; i_valid = 1'b0; mac_done = 1'b0;
    #1;
    chk_rst("s47_released");
    nxt();
    chk("s47_no_done", 32'({busy, done, err}), 32'h0);
    run_pass(4'd2, 12'd1, 8'd2, nwr, bad, acc, o0, o1, o2, rounds, dcyc);
    chk("s47_pass_wr", 32'(nwr), 32'd2);
    chk("s47_pass_bad", 32'(bad), 32'd0);
    chk("s47_pass_out", 32'(o0), 32'd2);
    chk("s47_pass_done", 32'(dcyc), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_pass_sequencer.md
CONV_PASS_SEQUENCER -- requirements
Module: conv_pass_sequencer

Interface
REQ-001 SHALL have parameter PE_ROWS, default 5, the number of PE array rows and the maximum filter height R.
REQ-002 SHALL have parameter PE_COLS, default 5, the number of PE array columns and the maximum filter width S.
REQ-003 SHALL have parameter MAC_PIPE_DEPTH, default 2, the MAC pipeline latency in cycles.
REQ-004 SHALL have port CLK, input, 1 bit, the clock; all logic is rising-edge.
REQ-005 SHALL have port RESETN, input, 1 bit, reset: synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle pulse that requests a convolution pass.
REQ-007 SHALL have port abort, input, 1 bit, a synchronous soft abort.
REQ-008 SHALL have port param_R, input, 4 bits, the filter height.
REQ-009 SHALL have port param_S, input, 4 bits, the filter width.
REQ-010 SHALL have port param_C, input, 12 bits, the input-channel count.
REQ-011 SHALL have port param_rows, input, 8 bits, the number of input rows streamed per channel.
REQ-012 SHALL have ports w_valid (input, 1 bit) and w_ready (output, 1 bit), forming the weight-row handshake.
REQ-013 SHALL have ports i_valid (input, 1 bit) and i_ready (output, 1 bit), forming the input-row handshake.
REQ-014 SHALL have port mac_done, input, 1 bit, a pulse when one psum row leaves the array.
REQ-015 SHALL have port weight_row_wr_en, output, 1 bit, the weight-row write strobe.
REQ-016 SHALL have port weight_row_wr_idx, output, 3 bits, the index of the weight row being written.
REQ-017 SHALL have port stall, output, 1 bit, which freezes the PE array.
REQ-018 SHALL have port psum_feedback_sel, output, 1 bit, which selects accumulation onto the fed-back psum.
REQ-019 SHALL have port out_wr_en, output, 1 bit, the output-storage write enable.
REQ-020 SHALL have ports busy (output, 1 bit), done (output, 1 bit, pulse) and err (output, 1 bit, pulse).

Function
REQ-021 SHALL implement the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-022 IDLE: on start with 1<=R<=PE_ROWS, 1<=S<=PE_COLS, C>=1 and rows>=1, SHALL latch R, S, C and rows, clear ch, and go to LOAD_W next cycle.
REQ-023 IDLE: on start with any parameter out of range, SHALL pulse err for 1 cycle and remain in IDLE.
REQ-024 SHALL ignore start whenever the state is not IDLE.
REQ-025 LOAD_W: w_ready=1; each w_valid&w_ready SHALL assert weight_row_wr_en in the same cycle with weight_row_wr_idx=wcnt, then increment wcnt.
REQ-026 LOAD_W: on the accept with wcnt==R-1, SHALL go to STREAM and clear wcnt and icnt.
REQ-027 STREAM: i_ready=1 and stall=~i_valid; each i_valid&i_ready SHALL increment icnt and pending.
REQ-028 STREAM: on the accept with icnt==rows-1, SHALL go to DRAIN.
REQ-029 SHALL keep pending as a 9-bit counter: +1 on an input accept, -1 on mac_done, unchanged when both occur in the same cycle.
REQ-030 SHALL pulse err for 1 cycle on mac_done while pending==0, leaving pending at 0.
REQ-031 DRAIN: stall=0; once pending==0, SHALL go to DONE if ch==C-1, else increment ch and go to LOAD_W.
REQ-032 SHALL drive psum_feedback_sel=1 exactly when ch>0 and the state is STREAM or DRAIN.
REQ-033 SHALL drive out_wr_en=mac_done while ch==C-1 in STREAM or DRAIN, and out_wr_en=0 otherwise.
REQ-034 DONE: SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-035 SHALL drive busy=1 in every state except IDLE.
REQ-036 SHALL drive stall=1 in IDLE, LOAD_W and DONE.
REQ-037 SHALL drive w_ready=0 outside LOAD_W and i_ready=0 outside STREAM.
REQ-038 On abort, SHALL go to IDLE on the next edge, clear all counters and suppress done; abort SHALL take priority over start.

Reset
REQ-039 While RESETN=0 at a clock edge, SHALL set the state to IDLE and clear ch, wcnt, icnt and pending.
REQ-040 While RESETN=0 at a clock edge, SHALL drive busy, done, err, w_ready, i_ready, weight_row_wr_en, out_wr_en and psum_feedback_sel to 0, stall to 1 and weight_row_wr_idx to 0.
REQ-041 Reset asserted mid-pass SHALL discard the pass and SHALL produce no done pulse.

Verification
REQ-042 R=3, S=3, C=1, rows=4, with valids held high -> weight_row_wr_idx goes 0,1,2; 4 input accepts; 4 out_wr_en pulses; done 1 cycle after pending reaches 0.
REQ-043 C=3, rows=2 -> 3 LOAD_W/STREAM rounds; psum_feedback_sel=0 in round 0 and 1 in rounds 1-2; out_wr_en only in round 2 (2 pulses).
REQ-044 start with R=6 or C=0 -> err for 1 cycle, busy stays 0.
REQ-045 i_valid toggling 1,0,1 in STREAM -> stall goes 0,1,0; input accept and mac_done in the same cycle -> pending unchanged.
REQ-046 abort during DRAIN with pending=2 -> next cycle IDLE, busy=0, no done; a later mac_done -> err pulse.
REQ-047 RESETN=0 in the middle of LOAD_W -> all outputs take their reset values (REQ-040), and a new start then runs normally.
